// File: rtl/inport_request_controller_pkg.sv
// inport_request_controller_pkg: shared types and helpers for the input-port request controller
package inport_request_controller_pkg;
    typedef enum logic [2:0] {X_POS, X_NEG, Y_POS, Y_NEG, LOCAL} port_dir_e;
    typedef enum logic [1:0] {IRC_IDLE, IRC_REQUEST, IRC_TRANSFER, IRC_RELEASE} irc_state_e;
    localparam int PORTS = 4;
    localparam int FLITS_PER_PACKET_DEF = 5;
    function automatic logic [PORTS-1:0] lowest_bit(input logic [PORTS-1:0] v);
        return v & (~v + 1'b1);
    endfunction
    function automatic logic multi_hot(input logic [PORTS-1:0] v);
        return |(v & (v - 1'b1));
    endfunction
endpackage

// File: rtl/inport_request_controller_if.sv
// inport_request_controller_if: FIFO, routing and scheduler handshake of one router input port
interface inport_request_controller_if;
    import inport_request_controller_pkg::*;
    logic             buffer_empty_din;
    logic [PORTS-1:0] route_request_din;
    logic [PORTS-1:0] transfer_strobe_din;
    logic [PORTS-1:0] port_request_dout;
    logic             buffer_read_dout;
    logic             credit_out_dout;
    logic             busy_dout;
    logic             protocol_error_dout;
    modport slave (
        input  buffer_empty_din, route_request_din, transfer_strobe_din,
        output port_request_dout, buffer_read_dout, credit_out_dout, busy_dout, protocol_error_dout
    );
    modport master (
        output buffer_empty_din, route_request_din, transfer_strobe_din,
        input  port_request_dout, buffer_read_dout, credit_out_dout, busy_dout, protocol_error_dout
    );
endinterface

// File: rtl/inport_request_controller_control_unit.sv
// inport_request_controller_control_unit: packet FSM, flit counter and sticky protocol error
module inport_request_controller_control_unit
    import inport_request_controller_pkg::*;
#(
    parameter port_dir_e PORT_DIR         = X_POS,
    parameter int        FLITS_PER_PACKET = FLITS_PER_PACKET_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic any_route,
    input  logic multi_route,
    input  logic buffer_empty,
    input  logic accepted_strobe,
    input  logic stray_strobe,
    output logic latch_route,
    output logic clear_request,
    output logic busy,
    output logic protocol_error
);
    localparam int CW = $clog2(FLITS_PER_PACKET + 1);
    localparam logic [CW-1:0] LAST = CW'(FLITS_PER_PACKET);

    if (FLITS_PER_PACKET < 2 || FLITS_PER_PACKET > 15) begin : g_bad_len
        $error("FLITS_PER_PACKET must be within 2..15");
    end
    if (PORT_DIR > LOCAL) begin : g_bad_dir
        $error("PORT_DIR is not a known port direction");
    end

    irc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IRC_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q | stray_strobe;
        latch_route   = 1'b0;
        clear_request = 1'b0;
        case (state_q)
            IRC_IDLE: if (!buffer_empty && any_route) begin
                latch_route = 1'b1;
                cnt_d       = '0;
                err_d       = err_d | multi_route;
                state_d     = IRC_REQUEST;
            end
            IRC_REQUEST: if (accepted_strobe) begin
                cnt_d   = CW'(1);
                state_d = IRC_TRANSFER;
            end
            IRC_TRANSFER: if (accepted_strobe) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == LAST) begin
                    clear_request = 1'b1;
                    state_d       = IRC_RELEASE;
                end
            end
            default: state_d = IRC_IDLE;
        endcase
    end

    assign busy           = state_q == IRC_REQUEST || state_q == IRC_TRANSFER;
    assign protocol_error = err_q;
endmodule

// File: rtl/inport_request_controller.sv
// inport_request_controller: holds a one-hot output request per packet and pops/credits one flit per strobe
module inport_request_controller
    import inport_request_controller_pkg::*;
#(
    parameter port_dir_e PORT_DIR         = X_POS,
    parameter int        FLITS_PER_PACKET = FLITS_PER_PACKET_DEF
) (
    input logic clk,
    input logic reset,
    inport_request_controller_if.slave bus
);
    logic [PORTS-1:0] req_q, req_d;
    logic             credit_q, credit_d;
    logic             accepted, stray, latch_route, clear_request, busy, protocol_error;

    // A strobe counts only if it comes from the scheduler we requested and there is a flit to give.
    always_comb begin
        accepted = |(bus.transfer_strobe_din & req_q) && !bus.buffer_empty_din;
        stray    = |(bus.transfer_strobe_din & ~req_q) || (|(bus.transfer_strobe_din & req_q) && bus.buffer_empty_din);
        req_d    = clear_request ? '0 : latch_route ? lowest_bit(bus.route_request_din) : req_q;
        credit_d = accepted;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= '0;
            credit_q <= 1'b0;
        end else begin
            req_q    <= req_d;
            credit_q <= credit_d;
        end
    end

    inport_request_controller_control_unit #(
        .PORT_DIR        (PORT_DIR),
        .FLITS_PER_PACKET(FLITS_PER_PACKET)
    ) u_cu (
        .clk            (clk),
        .reset          (reset),
        .any_route      (|bus.route_request_din),
        .multi_route    (multi_hot(bus.route_request_din)),
        .buffer_empty   (bus.buffer_empty_din),
        .accepted_strobe(accepted),
        .stray_strobe   (stray),
        .latch_route    (latch_route),
        .clear_request  (clear_request),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    assign bus.port_request_dout   = req_q;
    assign bus.buffer_read_dout    = accepted;
    assign bus.credit_out_dout     = credit_q;
    assign bus.busy_dout           = busy;
    assign bus.protocol_error_dout = protocol_error;
endmodule
